// File: rtl/win_regfile.sv
// Windowed register file with shared globals, push/pop window rotation and an
// automatic spill/fill engine that moves whole windows to and from data memory.
//
// Memory handshake: mem_req is the "valid" side and mem_ack the "ready" side.
// A word transfers on a rising edge where mem_req = 1 and mem_ack = 1. Until
// that edge mem_we, mem_addr and mem_wdata hold steady. mem_req stays high
// across consecutive words and drops on the edge that acknowledges the last
// word. Fill data is taken from mem_rdata on the acknowledging edge.
module win_regfile #(
  parameter int                WIDTH      = 16,
  parameter int                NWIN       = 4,
  parameter int                GLOBALS    = 4,
  parameter int                WIN_REGS   = 4,
  parameter int                MEM_AW     = 10,
  parameter logic [MEM_AW-1:0] SPILL_BASE = 10'h380,
  parameter int                MAX_SPILL  = 8,
  localparam int               RA_W       = $clog2(GLOBALS + WIN_REGS),
  localparam int               WP_W       = $clog2(NWIN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RA_W-1:0]   rd_addr1,
  input  logic [RA_W-1:0]   rd_addr2,
  output logic [WIDTH-1:0]  rd_data1,
  output logic [WIDTH-1:0]  rd_data2,
  input  logic [RA_W-1:0]   wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              reg_write,
  input  logic              ld_wnd,
  input  logic [WP_W-1:0]   wnd_in,
  input  logic              push,
  input  logic              pop,
  output logic [WP_W-1:0]   cwp,
  output logic              busy,
  output logic              ovf,
  output logic              unf,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata,
  input  logic              mem_ack,
  output logic [1:0]        fsm_state
);

  localparam int WI_W = (WIN_REGS > 1) ? $clog2(WIN_REGS) : 1;
  localparam int GI_W = (GLOBALS > 1) ? $clog2(GLOBALS) : 1;
  localparam int RS_W = $clog2(NWIN + 1);
  localparam int DP_W = $clog2(MAX_SPILL + 1);
  localparam logic [RA_W-1:0] G_A = RA_W'(GLOBALS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPILL = 2'd1,
    FILL  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] glob_q [GLOBALS];
  logic [WIDTH-1:0] loc_q  [NWIN][WIN_REGS];

  logic [WP_W-1:0] cwp_q;
  logic [WP_W-1:0] xwin_q;      // victim (spill) or target (fill) window
  logic [RS_W-1:0] resident_q;  // windows held on chip, 1..NWIN
  logic [DP_W-1:0] depth_q;     // windows held in memory, 0..MAX_SPILL
  logic [WI_W-1:0] idx_q;       // word within the window being moved
  logic            ovf_q, unf_q;
  logic [DP_W-1:0] slot;

  logic go_ld, go_push_fast, go_pop_fast, go_spill, go_fill;
  logic set_ovf, set_unf, word_done, last_word;

  // Combinational reads always see the current window, even mid-transfer.
  assign rd_data1 = (rd_addr1 < G_A) ? glob_q[GI_W'(rd_addr1)]
                                     : loc_q[cwp_q][WI_W'(rd_addr1 - G_A)];
  assign rd_data2 = (rd_addr2 < G_A) ? glob_q[GI_W'(rd_addr2)]
                                     : loc_q[cwp_q][WI_W'(rd_addr2 - G_A)];

  // A fill reads the topmost memory slot; a spill writes the next free one.
  assign slot      = (state_q == FILL) ? depth_q - 1'b1 : depth_q;
  assign mem_addr  = SPILL_BASE + (MEM_AW'(slot) * MEM_AW'(WIN_REGS)) + MEM_AW'(idx_q);
  assign mem_wdata = loc_q[xwin_q][idx_q];
  assign busy      = (state_q != IDLE);
  assign mem_req   = busy;
  assign mem_we    = (state_q == SPILL);
  assign cwp       = cwp_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;
  assign fsm_state = state_q;

  // Next-state and operation decode; commands are only honoured in IDLE.
  always_comb begin
    state_d      = state_q;
    go_ld        = 1'b0;
    go_push_fast = 1'b0;
    go_pop_fast  = 1'b0;
    go_spill     = 1'b0;
    go_fill      = 1'b0;
    set_ovf      = 1'b0;
    set_unf      = 1'b0;
    word_done    = 1'b0;
    last_word    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ld_wnd) begin
          go_ld = 1'b1;
        end else if (push && !pop) begin
          if (resident_q < RS_W'(NWIN)) begin
            go_push_fast = 1'b1;
          end else if (depth_q < DP_W'(MAX_SPILL)) begin
            go_spill = 1'b1;
            state_d  = SPILL;
          end else begin
            set_ovf = 1'b1;
          end
        end else if (pop && !push) begin
          if (resident_q > RS_W'(1)) begin
            go_pop_fast = 1'b1;
          end else if (depth_q != '0) begin
            go_fill = 1'b1;
            state_d = FILL;
          end else begin
            set_unf = 1'b1;
          end
        end
      end
      SPILL, FILL: begin
        word_done = mem_ack;
        last_word = mem_ack && (idx_q == WI_W'(WIN_REGS - 1));
        if (last_word) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Register file, window bookkeeping and transfer progress.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cwp_q      <= '0;
      xwin_q     <= '0;
      resident_q <= RS_W'(1);
      depth_q    <= '0;
      idx_q      <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      for (int g = 0; g < GLOBALS; g++) glob_q[g] <= '0;
      for (int w = 0; w < NWIN; w++)
        for (int i = 0; i < WIN_REGS; i++) loc_q[w][i] <= '0;
    end else begin
      // Writes go through the window current before any same-cycle rotation.
      if (state_q == IDLE && reg_write) begin
        if (wr_addr < G_A) glob_q[GI_W'(wr_addr)] <= wr_data;
        else               loc_q[cwp_q][WI_W'(wr_addr - G_A)] <= wr_data;
      end
      if (go_ld) begin
        cwp_q      <= wnd_in;
        resident_q <= RS_W'(1);
        depth_q    <= '0;
      end
      if (go_push_fast) begin
        cwp_q      <= cwp_q + 1'b1;
        resident_q <= resident_q + 1'b1;
      end
      if (go_pop_fast) begin
        cwp_q      <= cwp_q - 1'b1;
        resident_q <= resident_q - 1'b1;
      end
      // The oldest resident window sits just above cwp in the ring.
      if (go_spill) begin
        xwin_q <= cwp_q + 1'b1;
        idx_q  <= '0;
      end
      if (go_fill) begin
        xwin_q <= cwp_q - 1'b1;
        idx_q  <= '0;
      end
      if (set_ovf) ovf_q <= 1'b1;
      if (set_unf) unf_q <= 1'b1;
      if (word_done) begin
        idx_q <= idx_q + 1'b1;
        if (state_q == FILL) loc_q[xwin_q][idx_q] <= mem_rdata;
      end
      // cwp moves only once the whole window has been transferred.
      if (last_word) begin
        cwp_q <= xwin_q;
        if (state_q == SPILL) depth_q <= depth_q + 1'b1;
        else                  depth_q <= depth_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_win_regfile.sv
// Bench for win_regfile: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a window-level model.
module tb_win_regfile;

  localparam int WIDTH      = 16;
  localparam int NWIN       = 4;
  localparam int GLOBALS    = 4;
  localparam int WIN_REGS   = 4;
  localparam int MEM_AW     = 10;
  localparam int MAX_SPILL  = 8;
  localparam int SPILL_BASE = 'h380;
  localparam int EW         = 1 + MEM_AW + WIDTH;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [2:0]        rd_addr1 = '0, rd_addr2 = '0, wr_addr = '0;
  logic [WIDTH-1:0]  wr_data = '0;
  logic              reg_write = 1'b0, ld_wnd = 1'b0, push = 1'b0, pop = 1'b0;
  logic [1:0]        wnd_in = '0;
  logic [WIDTH-1:0]  rd_data1, rd_data2, mem_wdata, mem_rdata;
  logic [1:0]        cwp, fsm_state;
  logic              busy, ovf, unf, mem_req, mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_ack = 1'b0;

  always #5 clk = ~clk;

  win_regfile dut (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .wr_addr(wr_addr), .wr_data(wr_data), .reg_write(reg_write),
    .ld_wnd(ld_wnd), .wnd_in(wnd_in), .push(push), .pop(pop),
    .cwp(cwp), .busy(busy), .ovf(ovf), .unf(unf),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .fsm_state(fsm_state)
  );

  // ---------------- memory responder ----------------
  logic [WIDTH-1:0] tb_mem [1024];
  int               ack_delay = 0;

  assign mem_rdata = tb_mem[mem_addr];

  always @(posedge clk)
    if (rst && mem_req && mem_ack && mem_we) tb_mem[mem_addr] <= mem_wdata;

  initial begin : responder
    int wcnt;
    wcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (ack_delay == 0) begin
        mem_ack = 1'b1;
      end else if (mem_req) begin
        if (wcnt >= ack_delay) begin
          mem_ack = 1'b1;
          wcnt    = 0;
        end else begin
          mem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        mem_ack = 1'b0;
        wcnt    = 0;
      end
    end
  end

  // ---------------- scoreboard / model ----------------
  int  total = 0;
  int  bad   = 0;
  bit  chk_en = 1'b0;

  logic [WIDTH-1:0] m_glob [GLOBALS];
  logic [WIDTH-1:0] m_loc  [NWIN][WIN_REGS];
  logic [WIDTH-1:0] m_mem  [1024];
  int               m_cwp, m_res, m_depth, m_tgt, m_a, m_w;
  bit               m_busy, m_fill, m_ovf, m_unf;
  logic [EW-1:0]    exp_q [$];
  logic [EW-1:0]    e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] m_read(input int a);
    if (a < GLOBALS) return m_glob[a];
    return m_loc[m_cwp][a - GLOBALS];
  endfunction

  // Model: a transfer is booked as a whole on acceptance (its word list goes
  // into exp_q) and its architectural effect is applied once the list drains.
  always @(posedge clk) begin : model
    if (!rst) begin
      m_cwp = 0; m_res = 1; m_depth = 0; m_busy = 0; m_ovf = 0; m_unf = 0;
      for (int g = 0; g < GLOBALS; g++) m_glob[g] = '0;
      for (int w = 0; w < NWIN; w++)
        for (int i = 0; i < WIN_REGS; i++) m_loc[w][i] = '0;
      exp_q.delete();
    end else if (m_busy) begin
      if (mem_ack) begin
        if (exp_q.size() > 0) exp_q.delete(0);
        if (exp_q.size() == 0) begin
          if (m_fill) begin
            for (int i = 0; i < WIN_REGS; i++)
              m_loc[m_tgt][i] = m_mem[SPILL_BASE + (m_depth - 1) * WIN_REGS + i];
            m_depth--;
          end else begin
            m_depth++;
          end
          m_cwp  = m_tgt;
          m_busy = 0;
        end
      end
    end else begin
      if (reg_write) begin
        m_w = int'(wr_addr);
        if (m_w < GLOBALS) m_glob[m_w] = wr_data;
        else               m_loc[m_cwp][m_w - GLOBALS] = wr_data;
      end
      if (ld_wnd) begin
        m_cwp = int'(wnd_in); m_res = 1; m_depth = 0;
      end else if (push && !pop) begin
        if (m_res < NWIN) begin
          m_cwp = (m_cwp + 1) % NWIN; m_res++;
        end else if (m_depth < MAX_SPILL) begin
          m_tgt = (m_cwp + 1) % NWIN; m_fill = 0; m_busy = 1;
          for (int i = 0; i < WIN_REGS; i++) begin
            m_a = SPILL_BASE + m_depth * WIN_REGS + i;
            m_mem[m_a] = m_loc[m_tgt][i];
            exp_q.push_back({1'b1, MEM_AW'(m_a), m_loc[m_tgt][i]});
          end
        end else begin
          m_ovf = 1;
        end
      end else if (pop && !push) begin
        if (m_res > 1) begin
          m_cwp = (m_cwp + NWIN - 1) % NWIN; m_res--;
        end else if (m_depth > 0) begin
          m_tgt = (m_cwp + NWIN - 1) % NWIN; m_fill = 1; m_busy = 1;
          for (int i = 0; i < WIN_REGS; i++) begin
            m_a = SPILL_BASE + (m_depth - 1) * WIN_REGS + i;
            exp_q.push_back({1'b0, MEM_AW'(m_a), 16'h0000});
          end
        end else begin
          m_unf = 1;
        end
      end
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin : compare
    if (chk_en) begin
      check("cwp", 32'(cwp), 32'(m_cwp));
      check("busy", 32'(busy), 32'(m_busy));
      check("mem_req", 32'(mem_req), 32'(m_busy));
      check("ovf", 32'(ovf), 32'(m_ovf));
      check("unf", 32'(unf), 32'(m_unf));
      check("rd_data1", 32'(rd_data1), 32'(m_read(int'(rd_addr1))));
      check("rd_data2", 32'(rd_data2), 32'(m_read(int'(rd_addr2))));
      if (m_busy && exp_q.size() > 0) begin
        e = exp_q[0];
        check("mem_we", 32'(mem_we), 32'(e[EW-1]));
        check("mem_addr", 32'(mem_addr), 32'(e[EW-2 -: MEM_AW]));
        if (e[EW-1]) check("mem_wdata", 32'(mem_wdata), 32'(e[WIDTH-1:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    rd_addr1 = 3'($urandom_range(0, 7));
    rd_addr2 = 3'($urandom_range(0, 7));
  endtask

  task automatic clear_ops();
    push = 1'b0; pop = 1'b0; ld_wnd = 1'b0; reg_write = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0; step(); rst = 1'b1;
  endtask

  task automatic wr(input int a, input logic [WIDTH-1:0] d);
    reg_write = 1'b1; wr_addr = 3'(a); wr_data = d;
    step();
    reg_write = 1'b0;
  endtask

  task automatic op_push();
    push = 1'b1; step(); push = 1'b0;
  endtask

  task automatic op_pop();
    pop = 1'b1; step(); pop = 1'b0;
  endtask

  task automatic rd_check(input int a, input logic [WIDTH-1:0] exp, input string nm);
    rd_addr1 = 3'(a);
    #1;
    check(nm, 32'(rd_data1), 32'(exp));
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      step();
    end
    check("idle_reached", 32'(busy), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin : driver
    int n, r, pp;
    rst = 1'b0;
    step(); step();
    rst = 1'b1;
    chk_en = 1'b1;

    // Reset clears registers and pointers.
    wr(5, 16'h1234);
    rd_check(5, 16'h1234, "r5_written");
    do_reset();
    rd_check(5, 16'h0000, "r5_after_reset");
    check("cwp_after_reset", 32'(cwp), 32'd0);
    check("busy_after_reset", 32'(busy), 32'd0);
    check("req_after_reset", 32'(mem_req), 32'd0);

    // Globals are shared, locals follow the window.
    wr(1, 16'hAAAA);
    wr(4, 16'h1111);
    op_push();
    rd_check(1, 16'hAAAA, "global_after_push");
    rd_check(4, 16'h0000, "local_after_push");
    check("cwp_after_push", 32'(cwp), 32'd1);
    op_pop();
    rd_check(4, 16'h1111, "local_after_pop");
    check("cwp_after_pop", 32'(cwp), 32'd0);

    // Spill of window 0 on the fourth push, ack tied high.
    do_reset();
    for (int i = 0; i < WIN_REGS; i++) wr(4 + i, 16'(i + 1));
    repeat (3) op_push();
    check("cwp_three_push", 32'(cwp), 32'd3);
    op_push();
    wait_idle(n);
    check("spill_busy_cycles", 32'(n), 32'd4);
    check("cwp_after_spill", 32'(cwp), 32'd0);
    for (int i = 0; i < WIN_REGS; i++)
      check("spill_mem_word", 32'(tb_mem[SPILL_BASE + i]), 32'(i + 1));

    // Fill restores window 0 on the fourth pop; fifth pop underflows.
    for (int i = 0; i < WIN_REGS; i++) wr(4 + i, 16'h0000);
    repeat (3) op_pop();
    check("cwp_three_pop", 32'(cwp), 32'd1);
    op_pop();
    wait_idle(n);
    check("fill_busy_cycles", 32'(n), 32'd4);
    check("cwp_after_fill", 32'(cwp), 32'd0);
    for (int i = 0; i < WIN_REGS; i++) rd_check(4 + i, 16'(i + 1), "fill_restored");
    op_pop();
    check("unf_set", 32'(unf), 32'd1);
    check("cwp_after_unf", 32'(cwp), 32'd0);

    // Handshake stall: three wait cycles per word, commands during busy ignored.
    do_reset();
    ack_delay = 3;
    wr(1, 16'h5555);
    repeat (3) op_push();
    op_push();
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (n == 2) begin
        reg_write = 1'b1; wr_addr = 3'd1; wr_data = 16'hDEAD; push = 1'b1;
      end
      step();
      clear_ops();
    end
    check("stall_busy_cycles", 32'(n), 32'd16);
    check("cwp_after_stall", 32'(cwp), 32'd0);
    rd_check(1, 16'h5555, "write_during_busy");
    ack_delay = 0;
    step();

    // Overflow once memory holds MAX_SPILL windows.
    do_reset();
    repeat (3) op_push();
    for (int k = 0; k < MAX_SPILL; k++) begin
      op_push();
      wait_idle(n);
    end
    op_push();
    check("ovf_set", 32'(ovf), 32'd1);
    check("ovf_no_req", 32'(mem_req), 32'd0);
    check("ovf_cwp", 32'(cwp), 32'd3);
    repeat (3 + MAX_SPILL) begin
      op_pop();
      wait_idle(n);
    end
    check("cwp_unwound", 32'(cwp), 32'd0);
    check("ovf_sticky", 32'(ovf), 32'd1);
    ld_wnd = 1'b1; wnd_in = 2'd2; step(); ld_wnd = 1'b0;
    check("cwp_ld_wnd", 32'(cwp), 32'd2);

    // Randomized traffic, alternating push-heavy and pop-heavy phases.
    do_reset();
    for (int ph = 0; ph < 8; ph++) begin
      ack_delay = $urandom_range(0, 2);
      pp = (ph % 2 == 0) ? 35 : 15;
      for (int k = 0; k < 400; k++) begin
        r         = $urandom_range(0, 99);
        reg_write = ($urandom_range(0, 99) < 40);
        wr_addr   = 3'($urandom_range(0, 7));
        wr_data   = 16'($urandom);
        push      = (r < pp) || (r == 99);
        pop       = (r >= pp && r < 50) || (r == 99);
        ld_wnd    = ($urandom_range(0, 199) == 0);
        wnd_in    = 2'($urandom_range(0, 3));
        rst       = ($urandom_range(0, 499) != 0);
        step();
        clear_ops();
        rst = 1'b1;
      end
    end
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
